// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL with a runtime amount, one register stage per
// amount bit, valid/ready on both sides and a global stall.
module shift_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int unsigned LOG2W = $clog2(WIDTH);

  typedef enum logic [1:0] {ModeSll = 2'b00, ModeSrl = 2'b01, ModeSra = 2'b10, ModeRol = 2'b11}
    mode_e;

  logic             stall;
  logic             oversize;
  logic [WIDTH-1:0] pre_data;
  logic [LOG2W-1:0] pre_amt;

  logic [WIDTH-1:0] stage_in  [LOG2W];
  mode_e            mode_in   [LOG2W];
  logic [LOG2W-1:0] amt_in    [LOG2W];
  logic [WIDTH-1:0] stage_out [LOG2W];

  logic [WIDTH-1:0] data_q [LOG2W];
  mode_e            mode_q [LOG2W-1];
  logic [LOG2W-1:0] amt_q  [LOG2W-1];
  logic [LOG2W-1:0] valid_q;
  logic             zero_q;

  logic unused_amt;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input mode_e m,
                                                input int unsigned sh);
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      ModeSll: r = d << sh;
      ModeSrl: r = d >> sh;
      ModeSra: r = $signed(d) >>> sh;
      ModeRol: r = (d << sh) | (d >> (WIDTH - sh));
    endcase
    return r;
  endfunction

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_q[LOG2W-1];
  assign out_data  = data_q[LOG2W-1];
  assign out_zero  = zero_q;

  always_comb begin
    oversize = |in_amt[AMT_W-1:LOG2W];
    pre_data = in_data;
    pre_amt  = in_amt[LOG2W-1:0];
    if (oversize) begin
      unique case (mode_e'(in_mode))
        ModeSll, ModeSrl: begin
          pre_data = '0;
          pre_amt  = '0;
        end
        // WIDTH is a power of two, so WIDTH-1 is all ones in LOG2W bits.
        ModeSra: pre_amt = '1;
        ModeRol: pre_amt = in_amt[LOG2W-1:0];
      endcase
    end
  end

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_in[k] = pre_data;
      assign mode_in[k]  = mode_e'(in_mode);
      assign amt_in[k]   = pre_amt;
    end else begin : g_rest
      assign stage_in[k] = data_q[k-1];
      assign mode_in[k]  = mode_q[k-1];
      assign amt_in[k]   = amt_q[k-1];
    end
    assign stage_out[k] = amt_in[k][k] ? shift_by(stage_in[k], mode_in[k], 1 << k) : stage_in[k];
  end

  // Only the top amount bit is consumed by the final stage.
  assign unused_amt = ^amt_in[LOG2W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= {valid_q[LOG2W-2:0], in_valid};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      for (int k = 0; k < LOG2W; k++) data_q[k] <= '0;
      for (int k = 0; k < LOG2W - 1; k++) begin
        mode_q[k] <= ModeSll;
        amt_q[k]  <= '0;
      end
    end else if (!stall) begin
      zero_q <= (stage_out[LOG2W-1] == '0);
      for (int k = 0; k < LOG2W; k++) data_q[k] <= stage_out[k];
      for (int k = 0; k < LOG2W - 1; k++) begin
        mode_q[k] <= mode_in[k];
        amt_q[k]  <= amt_in[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe at WIDTH=16 and WIDTH=32 against a bitwise reference model.
module tb_shift_pipe;

  typedef struct {
    logic [31:0] data;
    time         t;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    int          a;
    logic [1:0]  m;
    logic [31:0] e;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_zero;
  logic [15:0] in_data = '0, out_data;
  logic [7:0]  in_amt = '0;
  logic [1:0]  in_mode = '0;

  logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1, w_out_zero;
  logic [31:0] w_in_data = '0, w_out_data;
  logic [7:0]  w_in_amt = '0;
  logic [1:0]  w_in_mode = '0;

  int   n_checks = 0, n_fail = 0, pops16 = 0, p;
  exp_t q16[$], q32[$];
  time  pop_t[$];
  bit   lat_en = 1'b1, stalled_prev = 1'b0;
  logic [15:0] held16;

  vec_t dir16[12] = '{
    '{32'h0001, 2, 2'd0, 32'h0004}, '{32'h0010, 3, 2'd0, 32'h0080},
    '{32'hFFFF, 2, 2'd0, 32'hFFFC}, '{32'h0002, 255, 2'd0, 32'h0000},
    '{32'h8000, 16, 2'd1, 32'h0000}, '{32'h8000, 200, 2'd2, 32'hFFFF},
    '{32'h7FFF, 16, 2'd2, 32'h0000}, '{32'hF000, 4, 2'd2, 32'hFF00},
    '{32'hF000, 4, 2'd1, 32'h0F00}, '{32'h8001, 1, 2'd3, 32'h0003},
    '{32'h1234, 20, 2'd3, 32'h2341}, '{32'hABCD, 0, 2'd3, 32'hABCD}};

  vec_t dir32[9] = '{
    '{32'h00000001, 31, 2'd0, 32'h80000000}, '{32'h00000001, 2, 2'd0, 32'h00000004},
    '{32'h00000010, 3, 2'd0, 32'h00000080}, '{32'hFFFFFFFF, 2, 2'd0, 32'hFFFFFFFC},
    '{32'hF0000000, 4, 2'd2, 32'hFF000000}, '{32'hF0000000, 4, 2'd1, 32'h0F000000},
    '{32'h80000001, 1, 2'd3, 32'h00000003}, '{32'h12345678, 36, 2'd3, 32'h23456781},
    '{32'hABCDEF01, 0, 2'd3, 32'hABCDEF01}};

  shift_pipe #(.WIDTH(16), .AMT_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero));

  shift_pipe #(.WIDTH(32), .AMT_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_amt(w_in_amt), .in_mode(w_in_mode), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_data(w_out_data), .out_zero(w_out_zero));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each result bit is fetched from the source bit it logically comes from.
  function automatic logic [31:0] ref_shift(int w, logic [31:0] d, int amt, logic [1:0] mode);
    logic [31:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (mode)
        2'd0: begin src = i - amt; r[i] = (src >= 0) ? d[src] : 1'b0; end
        2'd1: begin src = i + amt; r[i] = (src < w) ? d[src] : 1'b0; end
        2'd2: begin src = i + amt; r[i] = (src < w) ? d[src] : d[w-1]; end
        default: begin src = (i - (amt % w) + w) % w; r[i] = d[src]; end
      endcase
    end
    return r;
  endfunction

  task automatic send16(input logic [15:0] d, input int a, input logic [1:0] m,
                        input logic [31:0] e);
    exp_t x;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_amt = 8'(a); in_mode = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    check("accept16", 32'(in_ready), 32'd1);
    if (in_ready) begin
      x.data = e; x.t = $time; x.lat = lat_en;
      q16.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input int a, input logic [1:0] m,
                        input logic [31:0] e);
    exp_t x;
    int n = 0;
    w_in_valid = 1'b1; w_in_data = d; w_in_amt = 8'(a); w_in_mode = m;
    @(negedge clk);
    while (!w_in_ready && n < 200) begin n++; @(negedge clk); end
    check("accept32", 32'(w_in_ready), 32'd1);
    if (w_in_ready) begin
      x.data = e; x.t = $time; x.lat = 1'b1;
      q32.push_back(x);
    end
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  task automatic rand16();
    logic [15:0] d;
    int a;
    logic [1:0] m;
    d = 16'($urandom);
    a = ($urandom % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
    m = 2'($urandom % 4);
    send16(d, a, m, ref_shift(16, {16'h0, d}, a, m));
  endtask

  task automatic rand32();
    logic [31:0] d;
    int a;
    logic [1:0] m;
    d = $urandom;
    a = ($urandom % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
    m = 2'($urandom % 4);
    send32(d, a, m, ref_shift(32, d, a, m));
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 200) begin n++; @(negedge clk); end
    check("drain16", 32'(q16.size()), 32'd0);
    check("drain32", 32'(q32.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready16", 32'(in_ready), 32'd0);
        if (stalled_prev) check("stall_data_stable16", 32'(out_data), 32'(held16));
        held16 = out_data;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          check("unexpected_out16", 32'(out_valid), 32'd0);
        end else begin
          e = q16.pop_front();
          check("data16", 32'(out_data), e.data);
          check("zero16", 32'(out_zero), 32'(e.data == 0));
          if (e.lat) check("latency16", 32'(($time - e.t) / 10), 32'd4);
          pop_t.push_back($time);
          pops16++;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && w_out_valid && w_out_ready) begin
      if (q32.size() == 0) begin
        check("unexpected_out32", 32'(w_out_valid), 32'd0);
      end else begin
        e = q32.pop_front();
        check("data32", w_out_data, e.data);
        check("zero32", 32'(w_out_zero), 32'(e.data == 0));
        if (e.lat) check("latency32", 32'(($time - e.t) / 10), 32'd5);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid16", 32'(out_valid), 32'd0);
    check("rst_out_data16", 32'(out_data), 32'd0);
    check("rst_out_zero16", 32'(out_zero), 32'd0);
    check("rst_in_ready16", 32'(in_ready), 32'd1);
    check("rst_out_valid32", 32'(w_out_valid), 32'd0);
    check("rst_out_data32", w_out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, one at a time, latency checked on each.
    foreach (dir16[i]) begin
      send16(dir16[i].d[15:0], dir16[i].a, dir16[i].m, dir16[i].e);
      drain();
    end

    // Back-to-back stream of 8 ops.
    pop_t.delete();
    for (int i = 0; i < 8; i++) rand16();
    drain();
    check("stream_count", 32'(pop_t.size()), 32'd8);
    if (pop_t.size() == 8) check("stream_consecutive", 32'((pop_t[7] - pop_t[0]) / 10), 32'd7);

    // Backpressure: out_ready low for 3 cycles mid-stream.
    lat_en = 1'b0;
    p = pops16;
    fork
      for (int i = 0; i < 10; i++) rand16();
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("backpressure_count", 32'(pops16 - p), 32'd10);

    // Random traffic with random backpressure.
    fork
      for (int i = 0; i < 40; i++) rand16();
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = ($urandom % 3 != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Flush with 3 ops in flight; the op presented alongside flush is dropped too.
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) send16(16'h00F0, 1, 2'd0, 32'h01E0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h5555; in_amt = 8'd1; in_mode = 2'd0;
    @(negedge clk);
    q16.delete();
    p = pops16;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (10) @(negedge clk);
    check("flush_no_results", 32'(pops16 - p), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while a result is stalled at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send16(16'hA5A5, 0, 2'd3, 32'hA5A5);
    #2;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_data", 32'(out_data), 32'hA5A5);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q16.delete();
    p = pops16;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_results", 32'(pops16 - p), 32'd0);
    @(posedge clk); #1;

    // WIDTH=32 instance: directed cases then a back-to-back random stream.
    foreach (dir32[i]) begin
      send32(dir32[i].d, dir32[i].a, dir32[i].m, dir32[i].e);
      drain();
    end
    for (int i = 0; i < 16; i++) rand32();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
